// File: rtl/video_jb_pkg.sv
// Shared types, constants and helpers for the jailbar artefact generator.
package video_jb_pkg;

  typedef enum logic [1:0] {
    JB_OFF   = 2'd0,
    JB_LIGHT = 2'd1,
    JB_HEAVY = 2'd2,
    JB_USER  = 2'd3
  } jb_mode_t;

  // Luma weights; they sum to 32 so the >> (DW+2) leaves a 3-bit luma.
  localparam int unsigned LumaKr = 10;
  localparam int unsigned LumaKg = 19;
  localparam int unsigned LumaKb = 3;

  // Preset taps; every tap not listed is zero.
  localparam int unsigned LightTap15 = 3;
  localparam int unsigned LightTap0  = 6;
  localparam int unsigned LightTap1  = 1;
  localparam int unsigned LightTap2  = 0;
  localparam int unsigned HeavyTap15 = 5;
  localparam int unsigned HeavyTap0  = 11;
  localparam int unsigned HeavyTap1  = 7;
  localparam int unsigned HeavyTap2  = 2;

  function automatic int unsigned preset_tap(input jb_mode_t mode, input int unsigned idx);
    int unsigned tap;
    tap = 0;
    if (mode == JB_LIGHT) begin
      case (idx)
        15:      tap = LightTap15;
        0:       tap = LightTap0;
        1:       tap = LightTap1;
        2:       tap = LightTap2;
        default: tap = 0;
      endcase
    end else if (mode == JB_HEAVY) begin
      case (idx)
        15:      tap = HeavyTap15;
        0:       tap = HeavyTap0;
        1:       tap = HeavyTap1;
        2:       tap = HeavyTap2;
        default: tap = 0;
      endcase
    end
    return tap;
  endfunction

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned max_val);
    int unsigned sum;
    sum = a + b;
    return (sum > max_val) ? max_val : sum;
  endfunction

endpackage

// File: rtl/video_jb_phase.sv
// Column phase counter for the jailbar generator: preloads while hsync is high, advances one
// step per pixel enable, and yields the pattern index (two pixels per tap) and the tint bit.
// With JB_FRAME_DRIFT_EN defined, the preload is offset by a per-frame drift counter that
// steps on each vsync rising edge so the bars crawl across the screen.
module video_jb_phase
  import video_jb_pkg::*;
#(
  parameter int unsigned PHASE_W = 6,
  parameter int unsigned TAPS    = 16,
  parameter int unsigned START   = 24
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      ce_pix_i,
  input  logic                      hsync_i,
  input  logic                      vsync_i,
  output logic [$clog2(TAPS)-1:0]   idx_o,
  output logic                      t_o
);

  localparam int unsigned IdxW = $clog2(TAPS);

  logic [PHASE_W-1:0] cnt_q, cnt_d;
  logic [PHASE_W-1:0] preload;

`ifdef JB_FRAME_DRIFT_EN
  logic [PHASE_W-1:0] drift_q, drift_d;
  logic               vsync_q, vsync_d;

  // Drift advances once per vsync rising edge, wrapping.
  always_comb begin
    vsync_d = vsync_i;
    drift_d = drift_q;
    if (vsync_i && !vsync_q) begin
      drift_d = drift_q + PHASE_W'(1);
    end
  end

  // Drift and vsync edge-detect registers.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      drift_q <= '0;
      vsync_q <= 1'b0;
    end else begin
      drift_q <= drift_d;
      vsync_q <= vsync_d;
    end
  end

  assign preload = PHASE_W'(START) + drift_q;
`else
  logic unused_vsync;
  assign unused_vsync = vsync_i;
  assign preload      = PHASE_W'(START);
`endif

  // Hold at preload during hsync, otherwise count enabled pixels.
  always_comb begin
    cnt_d = cnt_q;
    if (hsync_i) begin
      cnt_d = preload;
    end else if (ce_pix_i) begin
      cnt_d = cnt_q + PHASE_W'(1);
    end
  end

  // Phase counter register.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cnt_q <= PHASE_W'(START);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign idx_o = cnt_q[IdxW:1];
  assign t_o   = cnt_q[PHASE_W-1];

  // Bit 0 only selects the pixel within a tap pair.
  logic unused_cnt_lsb;
  assign unused_cnt_lsb = cnt_q[0];

endmodule

// File: rtl/video_jailbars_gen.sv
// VIC-IIe jailbar artefact generator on the RGB path, between palette lookup and mixer.
// Two ce_pix-gated stages: stage 1 registers pixel, syncs, mode, phase and luma; stage 2 looks
// up the tap, subtracts luma, applies the low-level tint and saturating add.
// Build option: JB_FRAME_DRIFT_EN makes the bar phase crawl one column per frame.
module video_jailbars_gen
  import video_jb_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned PHASE_W = 6,
  parameter int unsigned TAPS    = 16,
  parameter int unsigned ADJ_W   = 4,
  parameter int unsigned START   = 24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ce_pix,
  input  logic [1:0]              mode,
  input  logic                    hsync,
  input  logic                    vsync,
  input  logic [DW-1:0]           r_i,
  input  logic [DW-1:0]           g_i,
  input  logic [DW-1:0]           b_i,
  input  logic                    tbl_we,
  input  logic [$clog2(TAPS)-1:0] tbl_addr,
  input  logic [ADJ_W-1:0]        tbl_data,
  output logic [DW-1:0]           r_o,
  output logic [DW-1:0]           g_o,
  output logic [DW-1:0]           b_o,
  output logic                    hsync_o,
  output logic                    vsync_o
);

  localparam int unsigned IdxW   = $clog2(TAPS);
  localparam int unsigned LumaW  = DW + 5;
  localparam int unsigned AdjW1  = ADJ_W + 1;
  localparam int unsigned PixMax = (1 << DW) - 1;

  logic [IdxW-1:0] idx;
  logic            tint_bit;

  video_jb_phase #(
    .PHASE_W (PHASE_W),
    .TAPS    (TAPS),
    .START   (START)
  ) u_phase (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .ce_pix_i (ce_pix),
    .hsync_i  (hsync),
    .vsync_i  (vsync),
    .idx_o    (idx),
    .t_o      (tint_bit)
  );

  // User table
  logic [ADJ_W-1:0] tbl_q [TAPS];
  logic [ADJ_W-1:0] tbl_d [TAPS];

  // Stage 1
  logic [DW-1:0]   r_s1_q, r_s1_d, g_s1_q, g_s1_d, b_s1_q, b_s1_d;
  logic            hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d, t_s1_q, t_s1_d;
  jb_mode_t        mode_s1_q, mode_s1_d;
  logic [IdxW-1:0] idx_s1_q, idx_s1_d;
  logic [2:0]      luma_s1_q, luma_s1_d;

  // Stage 2 / outputs
  logic [DW-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
  logic            hs_q, hs_d, vs_q, vs_d;

  logic [LumaW-1:0] luma_sum;
  logic [ADJ_W-1:0] tap;
  logic [AdjW1-1:0] adj, adj_r, adj_g;
  logic             tint;

  assign luma_sum = LumaW'(LumaKr) * LumaW'(r_i) + LumaW'(LumaKg) * LumaW'(g_i)
                  + LumaW'(LumaKb) * LumaW'(b_i);

  // Table writes land at the edge regardless of ce_pix, so a same-cycle read sees the old tap.
  always_comb begin
    tbl_d = tbl_q;
    if (tbl_we) begin
      tbl_d[tbl_addr] = tbl_data;
    end
  end

  // Stage 1 next state: capture pixel, syncs, mode, phase and luma on ce_pix.
  always_comb begin
    r_s1_d    = r_s1_q;
    g_s1_d    = g_s1_q;
    b_s1_d    = b_s1_q;
    hs_s1_d   = hs_s1_q;
    vs_s1_d   = vs_s1_q;
    mode_s1_d = mode_s1_q;
    idx_s1_d  = idx_s1_q;
    t_s1_d    = t_s1_q;
    luma_s1_d = luma_s1_q;
    if (ce_pix) begin
      r_s1_d    = r_i;
      g_s1_d    = g_i;
      b_s1_d    = b_i;
      hs_s1_d   = hsync;
      vs_s1_d   = vsync;
      mode_s1_d = jb_mode_t'(mode);
      idx_s1_d  = idx;
      t_s1_d    = tint_bit;
      luma_s1_d = luma_sum[DW+4:DW+2];
    end
  end

  // Stage 2 next state: tap lookup, luma attenuation, tint and saturating add.
  always_comb begin
    tap = '0;
    case (mode_s1_q)
      JB_USER:            tap = tbl_q[idx_s1_q];
      JB_LIGHT, JB_HEAVY: tap = ADJ_W'(preset_tap(mode_s1_q, 32'(idx_s1_q)));
      default:            tap = '0;
    endcase

    adj = '0;
    if (mode_s1_q != JB_OFF && luma_s1_q != 3'd0 && AdjW1'(tap) > AdjW1'(luma_s1_q)) begin
      adj = AdjW1'(tap) - AdjW1'(luma_s1_q);
    end

    // Faint bars pick up a red/green fringe in the heavy and user patterns.
    tint  = (mode_s1_q == JB_HEAVY || mode_s1_q == JB_USER) && (adj != '0)
            && (adj < AdjW1'(4));
    adj_r = adj + AdjW1'(tint & t_s1_q);
    adj_g = adj + AdjW1'(tint & ~t_s1_q);

    r_d  = r_q;
    g_d  = g_q;
    b_d  = b_q;
    hs_d = hs_q;
    vs_d = vs_q;
    if (ce_pix) begin
      r_d  = DW'(sat_add(32'(r_s1_q), 32'(adj_r), PixMax));
      g_d  = DW'(sat_add(32'(g_s1_q), 32'(adj_g), PixMax));
      b_d  = DW'(sat_add(32'(b_s1_q), 32'(adj), PixMax));
      hs_d = hs_s1_q;
      vs_d = vs_s1_q;
    end
  end

  // Pipeline and table registers; reset flushes everything to zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tbl_q     <= '{default: '0};
      r_s1_q    <= '0;
      g_s1_q    <= '0;
      b_s1_q    <= '0;
      hs_s1_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
      mode_s1_q <= JB_OFF;
      idx_s1_q  <= '0;
      t_s1_q    <= 1'b0;
      luma_s1_q <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      tbl_q     <= tbl_d;
      r_s1_q    <= r_s1_d;
      g_s1_q    <= g_s1_d;
      b_s1_q    <= b_s1_d;
      hs_s1_q   <= hs_s1_d;
      vs_s1_q   <= vs_s1_d;
      mode_s1_q <= mode_s1_d;
      idx_s1_q  <= idx_s1_d;
      t_s1_q    <= t_s1_d;
      luma_s1_q <= luma_s1_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  assign r_o     = r_q;
  assign g_o     = g_q;
  assign b_o     = b_q;
  assign hsync_o = hs_q;
  assign vsync_o = vs_q;

endmodule

// File: tb/tb_video_jailbars_gen.sv
// Directed bench for video_jailbars_gen with hand-computed expected pixels per line.
module tb_video_jailbars_gen;

  localparam int NPIX = 18;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce_pix;
  logic [1:0] mode;
  logic       hsync, vsync;
  logic [7:0] r_i, g_i, b_i;
  logic       tbl_we;
  logic [3:0] tbl_addr;
  logic [3:0] tbl_data;
  logic [7:0] r_o, g_o, b_o;
  logic       hsync_o, vsync_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] exp_q [NPIX];

  always #5 clk = ~clk;

  video_jailbars_gen dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce_pix   (ce_pix),
    .mode     (mode),
    .hsync    (hsync),
    .vsync    (vsync),
    .r_i      (r_i),
    .g_i      (g_i),
    .b_i      (b_i),
    .tbl_we   (tbl_we),
    .tbl_addr (tbl_addr),
    .tbl_data (tbl_data),
    .r_o      (r_o),
    .g_o      (g_o),
    .b_o      (b_o),
    .hsync_o  (hsync_o),
    .vsync_o  (vsync_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One pixel: ce_pix high for the first cycle, low for the remaining div-1 cycles.
  task automatic apply(input int div);
    ce_pix = 1'b1;
    step();
    tbl_we = 1'b0;
    ce_pix = 1'b0;
    for (int i = 1; i < div; i++) step();
    ce_pix = 1'b1;
  endtask

  function automatic logic [23:0] grey(input logic [7:0] v);
    return {v, v, v};
  endfunction

  task automatic fill_exp(input logic [7:0] v);
    for (int i = 0; i < NPIX; i++) exp_q[i] = grey(v);
  endtask

  // Grey 40 (luma 1) in HEAVY; base is the pixel whose counter is 30 (tap 15).
  task automatic set_heavy40(input int base);
    fill_exp(8'd40);
    exp_q[base]   = grey(8'd44);
    exp_q[base+1] = grey(8'd44);
    exp_q[base+2] = grey(8'd50);
    exp_q[base+3] = grey(8'd50);
    exp_q[base+4] = grey(8'd46);
    exp_q[base+5] = grey(8'd46);
    exp_q[base+6] = {8'd42, 8'd41, 8'd41};
    exp_q[base+7] = {8'd42, 8'd41, 8'd41};
  endtask

  task automatic set_light40();
    fill_exp(8'd40);
    exp_q[6] = grey(8'd42);
    exp_q[7] = grey(8'd42);
    exp_q[8] = grey(8'd45);
    exp_q[9] = grey(8'd45);
  endtask

  // hsync for 3 pixels, then NPIX active pixels; mode switches to m1 from pixel sw_k on,
  // and tap 0 is cleared during pixel wr_k.
  task automatic run_line(input logic [1:0] m0, input logic [1:0] m1, input int sw_k,
                          input logic [7:0] pix, input int div, input int wr_k,
                          input string tag);
    {r_i, g_i, b_i} = grey(pix);
    mode  = m0;
    hsync = 1'b1;
    repeat (3) apply(div);
    hsync = 1'b0;
    for (int k = 0; k < NPIX; k++) begin
      mode = (k >= sw_k) ? m1 : m0;
      if (k == wr_k) begin
        tbl_we   = 1'b1;
        tbl_addr = 4'd0;
        tbl_data = 4'd0;
      end
      apply(div);
      if (k == 0) check_eq({tag, "_hs_hi"}, 32'(hsync_o), 32'd1);
      if (k == 1) check_eq({tag, "_hs_lo"}, 32'(hsync_o), 32'd0);
      if (k >= 1) check_eq($sformatf("%s_k%0d", tag, k - 1), 32'({r_o, g_o, b_o}), 32'(exp_q[k-1]));
    end
  endtask

  task automatic write_tap0(input logic [3:0] v);
    tbl_we   = 1'b1;
    tbl_addr = 4'd0;
    tbl_data = v;
    ce_pix   = 1'b0;
    step();
    tbl_we = 1'b0;
    ce_pix = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    ce_pix   = 1'b1;
    mode     = 2'd2;
    hsync    = 1'b1;
    vsync    = 1'b0;
    {r_i, g_i, b_i} = grey(8'd40);
    tbl_we   = 1'b0;
    tbl_addr = 4'd0;
    tbl_data = 4'd0;
    repeat (3) step();
    check_eq("reset_out", 32'({r_o, g_o, b_o, hsync_o, vsync_o}), 32'd0);
    reset_n = 1'b1;

    // HEAVY, LIGHT, mid-line LIGHT->HEAVY switch, OFF
    set_heavy40(6);
    run_line(2'd2, 2'd2, 99, 8'd40, 1, -1, "heavy");
    set_light40();
    run_line(2'd1, 2'd1, 99, 8'd40, 1, -1, "light");
    set_light40();
    exp_q[8]  = grey(8'd50);
    exp_q[9]  = grey(8'd50);
    exp_q[10] = grey(8'd46);
    exp_q[11] = grey(8'd46);
    exp_q[12] = {8'd42, 8'd41, 8'd41};
    exp_q[13] = {8'd42, 8'd41, 8'd41};
    run_line(2'd1, 2'd2, 8, 8'd40, 1, -1, "switch");
    fill_exp(8'd40);
    run_line(2'd0, 2'd0, 99, 8'd40, 1, -1, "off");

    // USER: tap0=15 saturates bright input; clearing it during pixel 9 leaves pixel 8 old
    write_tap0(4'd15);
    fill_exp(8'd250);
    exp_q[8] = grey(8'd255);
    run_line(2'd3, 2'd3, 99, 8'd250, 1, 9, "user");

    // Black input in every mode, then 1-of-3 pixel enable
    for (int m = 0; m < 4; m++) begin
      fill_exp(8'd0);
      run_line(2'(m), 2'(m), 99, 8'd0, 1, -1, $sformatf("black%0d", m));
    end
    set_heavy40(6);
    run_line(2'd2, 2'd2, 99, 8'd40, 3, -1, "ce3");

    // Three vsync pulses, then a HEAVY line
    hsync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vsync = 1'b1;
      step();
      if (i == 0) check_eq("vs_delay1", 32'(vsync_o), 32'd0);
      step();
      if (i == 0) check_eq("vs_delay2", 32'(vsync_o), 32'd1);
      vsync = 1'b0;
      step();
      step();
    end
`ifdef JB_FRAME_DRIFT_EN
    set_heavy40(3);
`else
    set_heavy40(6);
`endif
    run_line(2'd2, 2'd2, 99, 8'd40, 1, -1, "drift");

    // Reset mid-line
    write_tap0(4'd15);
    {r_i, g_i, b_i} = grey(8'd40);
    mode  = 2'd2;
    hsync = 1'b1;
    repeat (3) apply(1);
    hsync = 1'b0;
    repeat (5) apply(1);
    check_eq("pre_rst", 32'({r_o, g_o, b_o}), 32'(grey(8'd40)));
    reset_n = 1'b0;
    step();
    check_eq("rst_flush", 32'({r_o, g_o, b_o, hsync_o, vsync_o}), 32'd0);
    reset_n = 1'b1;
    apply(1);
    check_eq("rst_rel1", 32'({r_o, g_o, b_o}), 32'd0);
    apply(1);
    check_eq("rst_rel2", 32'({r_o, g_o, b_o}), 32'(grey(8'd40)));
    set_heavy40(6);
    run_line(2'd2, 2'd2, 99, 8'd40, 1, -1, "post_rst");
    fill_exp(8'd250);
    run_line(2'd3, 2'd3, 99, 8'd250, 1, -1, "tbl_clr");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
